// File: rtl/uart_rx_par_chk.sv
// -----------------------------------------------------------------------------
// uart_rx_par_chk
//
// Receive-side parity checker and deserialiser for the UART Rx path. It sits
// between the Rx bit sampler and the Rx FSM / stop-bit checker. Data bits
// arrive LSB first, one per BIT_STRB. Parity is accumulated serially and,
// when the frame carries parity, compared against the received parity bit.
//
// Parameters:
//   WIDTH      data bits per frame (5..16)
//   ERR_CNT_W  width of the saturating parity-error counter
//
// Ports:
//   CLK             system clock, rising edge
//   RST             asynchronous active-high reset
//   FRAME_START     pulse: start bit accepted, begin (or restart) a frame
//   BIT_STRB        pulse: SAMPLED_BIT is valid this cycle
//   SAMPLED_BIT     majority-voted Rx bit
//   PAR_EN          1 = frame carries a parity bit (latched at FRAME_START)
//   PAR_MODE        00 even, 01 odd, 10 mark, 11 space (latched at FRAME_START)
//   ERR_CNT_CLR     clears ERR_CNT and PAR_ERR_STICKY
//   P_DATA          deserialised data, valid with PAR_DONE, held until next start
//   PAR_DONE        one-cycle pulse: frame complete
//   PAR_ERR         one-cycle pulse with PAR_DONE on parity mismatch
//   PAR_ERR_STICKY  set on any PAR_ERR, held until ERR_CNT_CLR
//   ERR_CNT         saturating count of parity errors
//   BUSY            1 while in DATA or PARITY
// -----------------------------------------------------------------------------
module uart_rx_par_chk #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FRAME_START,
  input  logic                 BIT_STRB,
  input  logic                 SAMPLED_BIT,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic                 ERR_CNT_CLR,
  output logic [WIDTH-1:0]     P_DATA,
  output logic                 PAR_DONE,
  output logic                 PAR_ERR,
  output logic                 PAR_ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic                 BUSY
);

  localparam int                   CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PM_EVEN  = 2'b00,
    PM_ODD   = 2'b01,
    PM_MARK  = 2'b10,
    PM_SPACE = 2'b11
  } par_mode_t;

  state_t           state;
  logic             par_en_q;
  par_mode_t        par_mode_q;
  logic             acc;
  logic [CNT_W-1:0] bit_cnt;

  logic             exp_par;
  logic             par_err_evt;

  // Expected parity bit for the latched mode, and the mismatch event that both
  // drives PAR_ERR and feeds the error counter. A coincident FRAME_START
  // restarts the frame, so the parity strobe is discarded in that case.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    exp_par = 1'b0;
    unique case (par_mode_q)
      PM_EVEN:  exp_par = acc;
      PM_ODD:   exp_par = ~acc;
      PM_MARK:  exp_par = 1'b1;
      PM_SPACE: exp_par = 1'b0;
    endcase
    par_err_evt = (state == PARITY) && BIT_STRB && !FRAME_START &&
                  (SAMPLED_BIT != exp_par);
  end

  // NOTE: all state and outputs below are updated with non-blocking
  // assignments so every register samples pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      par_en_q       <= 1'b0;
      par_mode_q     <= PM_EVEN;
      acc            <= 1'b0;
      bit_cnt        <= '0;
      P_DATA         <= '0;
      PAR_DONE       <= 1'b0;
      PAR_ERR        <= 1'b0;
      PAR_ERR_STICKY <= 1'b0;
      ERR_CNT        <= '0;
      BUSY           <= 1'b0;
    end else begin
      PAR_DONE <= 1'b0;
      PAR_ERR  <= 1'b0;

      // Clear takes priority, but an error registered on the same edge still
      // counts, leaving the counter at one.
      if (ERR_CNT_CLR) begin
        ERR_CNT        <= par_err_evt ? ERR_CNT_W'(1) : '0;
        PAR_ERR_STICKY <= par_err_evt;
      end else if (par_err_evt) begin
        if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
        PAR_ERR_STICKY <= 1'b1;
      end

      if (FRAME_START) begin
        // Start or abort-and-restart; any strobe this cycle is discarded.
        state      <= DATA;
        BUSY       <= 1'b1;
        par_en_q   <= PAR_EN;
        par_mode_q <= par_mode_t'(PAR_MODE);
        acc        <= 1'b0;
        bit_cnt    <= '0;
        P_DATA     <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          DATA: begin
            if (BIT_STRB) begin
              acc             <= acc ^ SAMPLED_BIT;
              P_DATA[bit_cnt] <= SAMPLED_BIT;
              if (bit_cnt == LAST_BIT) begin
                if (par_en_q) begin
                  state <= PARITY;
                end else begin
                  state    <= IDLE;
                  BUSY     <= 1'b0;
                  PAR_DONE <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          PARITY: begin
            if (BIT_STRB) begin
              PAR_ERR  <= par_err_evt;
              PAR_DONE <= 1'b1;
              state    <= IDLE;
              BUSY     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_par_chk.md
Name: uart_rx_par_chk

Overview:
Parametrised receive-side parity checker for the UART Rx path. It accumulates parity serially over sampled data bits, compares it against the received parity bit, and deserialises the frame data (LSB first). Supports even/odd/mark/space modes, parity-disabled frames and a saturating error counter. It sits between the Rx bit sampler and the Rx FSM/stop-bit checker.

Parameters:
WIDTH, 8, number of data bits per frame (legal 5..16)
ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
FRAME_START  input  1  single-cycle pulse: start bit accepted, begin new frame
BIT_STRB  input  1  single-cycle pulse: SAMPLED_BIT is valid this cycle
SAMPLED_BIT  input  1  majority-voted Rx bit from sampler
PAR_EN  input  1  1 = frame carries parity bit
PAR_MODE  input  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
ERR_CNT_CLR  input  1  clears ERR_CNT and PAR_ERR_STICKY
P_DATA  output  WIDTH  deserialised data, valid when PAR_DONE=1, held until next FRAME_START
PAR_DONE  output  1  one-cycle pulse: frame data/parity complete
PAR_ERR  output  1  one-cycle pulse coincident with PAR_DONE on parity mismatch
PAR_ERR_STICKY  output  1  set on any PAR_ERR, held until ERR_CNT_CLR
ERR_CNT  output  ERR_CNT_W  saturating count of parity errors
BUSY  output  1  1 while in DATA or PARITY state

Behaviour:
- Reset (RST=1, async): state IDLE; P_DATA=0, PAR_DONE=0, PAR_ERR=0, PAR_ERR_STICKY=0, ERR_CNT=0, BUSY=0, accumulator and bit counter 0. Reset mid-frame abandons the frame with no PAR_DONE.
- All outputs registered. BUSY=1 exactly in DATA/PARITY.
- States: IDLE, DATA, PARITY.
- IDLE: FRAME_START -> DATA; latch PAR_EN and PAR_MODE into internal config (input changes mid-frame ignored); clear accumulator, bit counter, P_DATA. BIT_STRB ignored in IDLE.
- DATA: per BIT_STRB: acc <= acc ^ SAMPLED_BIT; shift bit into P_DATA at index = bit counter (LSB first); counter++. On strobe with counter = WIDTH-1: go PARITY if latched PAR_EN, else go IDLE and pulse PAR_DONE next cycle with PAR_ERR=0.
- PARITY: on BIT_STRB compute expected = acc (even), ~acc (odd), 1 (mark), 0 (space); PAR_ERR <= (SAMPLED_BIT != expected); PAR_DONE <= 1; go IDLE.
- Latency: PAR_DONE/PAR_ERR high in the cycle after the clock edge sampling the final strobe; width exactly one cycle.
- FRAME_START while BUSY: abort current frame (no PAR_DONE), restart as from IDLE using current PAR_EN/PAR_MODE.
- FRAME_START in same cycle as final strobe: final strobe ignored, restart wins.
- ERR_CNT: +1 per PAR_ERR pulse, saturates at 2^ERR_CNT_W-1 (no wrap). PAR_ERR_STICKY set with same edge as PAR_ERR.
- ERR_CNT_CLR same cycle as an error being registered: clear applied first, then the new error counts -> ERR_CNT=1, STICKY=1.
- BIT_STRB with no FRAME_START first: no effect. Back-to-back strobes (every cycle) supported.

Test Plan:
- Even mode, WIDTH=8, data 0xA5 (LSB first), parity bit 0 -> PAR_DONE pulse, P_DATA=0xA5, PAR_ERR=0, ERR_CNT=0.
- Odd mode, data 0xA5, parity bit 0 -> PAR_ERR=1 with PAR_DONE, STICKY=1, ERR_CNT=1; then data 0x01 parity 0 -> PAR_ERR=0, ERR_CNT stays 1.
- Mark/space: mark with parity bit 0 -> PAR_ERR=1; space with parity bit 0 -> PAR_ERR=0, regardless of data 0xFF.
- PAR_EN=0, data 0x3C -> PAR_DONE after 8th strobe, PAR_ERR=0; change PAR_EN to 1 mid-frame -> no effect on that frame.
- Abort/reset: FRAME_START after 4 data bits, then full frame 0x5A even/parity 0 -> single PAR_DONE, P_DATA=0x5A; RST asserted mid-frame -> all outputs 0 immediately, no PAR_DONE.
- ERR_CNT_W=2: 5 consecutive parity errors -> ERR_CNT saturates at 3; ERR_CNT_CLR coincident with 6th error -> ERR_CNT=1, STICKY=1.
